crc16_frame_checker: RTL and testbench

//  Receive-side counterpart of the CRC16-CCITT-X25 byte generator. Takes a byte stream
//  (payload followed by 2 FCS bytes, low byte first), recomputes the CRC, checks the

---
 rtl/crc_chk_pkg.sv | 21 ++
 rtl/crc16_byte_next.sv | 35 +++
 rtl/crc16_frame_checker.sv | 207 ++++++++++++++++++++
 tb/tb_crc16_frame_checker.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_chk_pkg.sv
// ---------------------------------------------------------------------------
// crc_chk_pkg
//   Shared constants and types for the CRC16-CCITT-X25 frame checker.
//   CRC_POLY    : generator polynomial x^16 + x^12 + x^5 + 1
//   CRC_INIT    : register preset at the start of every frame
//   CRC_RESIDUE : register value left by a frame whose FCS is correct, in the
//                 MSB-shifting register orientation used by crc16_byte_next
//   stateT      : receive FSM states
// ---------------------------------------------------------------------------
package crc_chk_pkg;

    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam logic [15:0] CRC_INIT    = 16'hFFFF;
    localparam logic [15:0] CRC_RESIDUE = 16'h1D0F;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } stateT;

endpackage

// File: rtl/crc16_byte_next.sv
// ---------------------------------------------------------------------------
// crc16_byte_next
//   Combinational one-byte CRC16 step. The register shifts towards bit 15 and
//   the data byte is consumed LSB first (reflected input), which is the X25
//   bit order on the wire.
// Ports
//   crcIn   [15:0] in  current CRC register value
//   data    [7:0]  in  byte to absorb
//   crcNext [15:0] out CRC register after absorbing data
// ---------------------------------------------------------------------------
module crc16_byte_next
    import crc_chk_pkg::*;
(
    input  logic [15:0] crcIn,
    input  logic [7:0]  data,
    output logic [15:0] crcNext
);

    logic [15:0] crcWork;

    // NOTE: blocking assignments here are deliberate; each loop pass must see
    // the value produced by the previous pass within the same evaluation.
    always_comb begin
        crcWork = crcIn;
        for (int i = 0; i < 8; i++) begin
            if (crcWork[15] ^ data[i]) begin
                crcWork = {crcWork[14:0], 1'b0} ^ CRC_POLY;
            end else begin
                crcWork = {crcWork[14:0], 1'b0};
            end
        end
        crcNext = crcWork;
    end

endmodule

// File: rtl/crc16_frame_checker.sv
// ---------------------------------------------------------------------------
// crc16_frame_checker
//   Receive-side X25 checker. Recomputes the CRC over each frame (payload plus
//   two FCS bytes, low byte first), checks the residue and length, reports a
//   one-cycle status pulse and forwards the byte stream one cycle later.
//
//   Build option CRC_CHK_STRIP_EN:
//     defined   - two-byte holdback strips the FCS; payload byte k leaves the
//                 cycle after byte k+2 arrives, outEof marks the last payload
//                 byte, short or aborted frames emit nothing further.
//     undefined - every accepted frame byte (FCS included) is forwarded one
//                 cycle later with inSof/inEof copied to outSof/outEof.
//
// Parameters
//   MAX_LEN  largest legal payload length in bytes (FCS excluded)
//   CNT_W    width of the saturating bad-frame counter
// Ports
//   clk, rstN                      clock, asynchronous active-low reset
//   inValid/inData/inSof/inEof     received byte stream, no backpressure
//   outValid/outData/outSof/outEof forwarded byte stream
//   frameDone                      one-cycle frame status pulse
//   frameOk                        frame status, qualified by frameDone
//   crcOut                         live CRC register
//   errCnt                         bad frames since reset, saturating
// ---------------------------------------------------------------------------
module crc16_frame_checker
    import crc_chk_pkg::*;
#(
    parameter int MAX_LEN = 256,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             inValid,
    input  logic [7:0]       inData,
    input  logic             inSof,
    input  logic             inEof,
    output logic             outValid,
    output logic [7:0]       outData,
    output logic             outSof,
    output logic             outEof,
    output logic             frameDone,
    output logic             frameOk,
    output logic [15:0]      crcOut,
    output logic [CNT_W-1:0] errCnt
);

    // Frame length counts every byte including FCS and sticks one past the
    // largest legal value, so oversize frames can never wrap back into range.
    localparam int               LEN_W   = $clog2(MAX_LEN + 4);
    localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 3);
    localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(3);

    stateT            state, stateNext;
    logic [15:0]      crcSeed, crcNext;
    logic [LEN_W-1:0] len, lenNext;
    logic             lenErr, lenErrNext;
    logic             startFrame, accept;
    logic             doneNext, okNext;

    // inSof always starts a frame, even mid-frame (that aborts the old one).
    assign startFrame = inValid && inSof;
    assign accept     = inValid && (inSof || state == RECV);
    assign crcSeed    = startFrame ? CRC_INIT : crcOut;

    crc16_byte_next uCrcNext (
        .crcIn   (crcSeed),
        .data    (inData),
        .crcNext (crcNext)
    );

    assign lenNext    = startFrame        ? LEN_W'(1) :
                        (len == LEN_SAT)  ? len       : len + LEN_W'(1);
    assign lenErrNext = !startFrame && (lenErr || lenNext == LEN_SAT);

    // NOTE: every output of this block gets a default first so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        stateNext = state;
        doneNext  = 1'b0;
        okNext    = 1'b0;
        case (state)
            IDLE: begin
                if (startFrame) begin
                    // A byte carrying both inSof and inEof is a 1-byte frame.
                    stateNext = inEof ? IDLE : RECV;
                    doneNext  = inEof;
                end
            end
            RECV: begin
                if (inValid) begin
                    stateNext = inEof ? IDLE : RECV;
                    doneNext  = inEof || inSof;
                    okNext    = inEof && !inSof
                                && (crcNext == CRC_RESIDUE)
                                && (lenNext >= LEN_MIN)
                                && !lenErrNext;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            crcOut    <= CRC_INIT;
            len       <= '0;
            lenErr    <= 1'b0;
            frameDone <= 1'b0;
            frameOk   <= 1'b0;
            errCnt    <= '0;
        end else begin
            frameDone <= doneNext;
            frameOk   <= okNext;
            if (doneNext && !okNext && errCnt != '1) begin
                errCnt <= errCnt + CNT_W'(1);
            end
            if (accept) begin
                crcOut <= crcNext;
                len    <= lenNext;
                lenErr <= lenErrNext;
            end
        end
    end

`ifdef CRC_CHK_STRIP_EN
    logic [1:0] holdCnt;
    logic       holdSof;     // oldest held byte is the frame's first byte
    logic [7:0] holdOld, holdNew;
    logic       emit;

    // Only a third (or later) byte of the same frame releases the oldest one;
    // a new inSof discards whatever is held.
    assign emit = accept && !startFrame && (holdCnt == 2'd2);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            holdCnt  <= 2'd0;
            holdSof  <= 1'b0;
            outValid <= 1'b0;
            outData  <= '0;
            outSof   <= 1'b0;
            outEof   <= 1'b0;
        end else begin
            outValid <= emit;
            outSof   <= emit && holdSof;
            outEof   <= emit && inEof;
            if (emit) begin
                outData <= holdOld;
                holdSof <= 1'b0;
            end
            if (startFrame) begin
                holdCnt <= inEof ? 2'd0 : 2'd1;
                holdSof <= 1'b1;
            end else if (accept) begin
                if (inEof) begin
                    holdCnt <= 2'd0;
                end else if (holdCnt != 2'd2) begin
                    holdCnt <= holdCnt + 2'd1;
                end
            end
        end
    end

    // NOTE: the held bytes are always qualified by holdCnt, so this storage
    // is left out of reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (startFrame || holdCnt == 2'd0) begin
                holdOld <= inData;
            end else if (holdCnt == 2'd1) begin
                holdNew <= inData;
            end else begin
                holdOld <= holdNew;
                holdNew <= inData;
            end
        end
    end
`else
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            outValid <= 1'b0;
            outData  <= '0;
            outSof   <= 1'b0;
            outEof   <= 1'b0;
        end else begin
            outValid <= accept;
            outSof   <= accept && inSof;
            outEof   <= accept && inEof;
            if (accept) begin
                outData <= inData;
            end
        end
    end
`endif

endmodule

// File: tb/tb_crc16_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_crc16_frame_checker
//   Two checkers share one input stream: dutA with default parameters and
//   dutB with MAX_LEN=4, CNT_W=2 (length limit and counter saturation).
//   Expected values come from a frame-level model: the received frame is kept
//   as a byte queue and its CRC is recomputed from scratch with the classic
//   reflected X25 algorithm (poly 0x8408, good residue 0xF0B8); the checker's
//   register is the bit-reverse of that value.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_crc16_frame_checker;

    typedef logic [7:0] byteQ[$];

    localparam int MAX_A = 256;
    localparam int MAX_B = 4;

    logic       clk     = 1'b0;
    logic       rstN    = 1'b0;
    logic       inValid = 1'b0;
    logic [7:0] inData  = 8'h00;
    logic       inSof   = 1'b0;
    logic       inEof   = 1'b0;

    logic        outValidA, outSofA, outEofA, frameDoneA, frameOkA;
    logic [7:0]  outDataA;
    logic [15:0] crcOutA, errCntA;
    logic        outValidB, outSofB, outEofB, frameDoneB, frameOkB;
    logic [7:0]  outDataB;
    logic [15:0] crcOutB;
    logic [1:0]  errCntB;

    always #5 clk = ~clk;

    crc16_frame_checker #(.MAX_LEN(MAX_A), .CNT_W(16)) dutA (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inData(inData),
        .inSof(inSof), .inEof(inEof), .outValid(outValidA), .outData(outDataA),
        .outSof(outSofA), .outEof(outEofA), .frameDone(frameDoneA),
        .frameOk(frameOkA), .crcOut(crcOutA), .errCnt(errCntA)
    );

    crc16_frame_checker #(.MAX_LEN(MAX_B), .CNT_W(2)) dutB (
        .clk(clk), .rstN(rstN), .inValid(inValid), .inData(inData),
        .inSof(inSof), .inEof(inEof), .outValid(outValidB), .outData(outDataB),
        .outSof(outSofB), .outEof(outEofB), .frameDone(frameDoneB),
        .frameOk(frameOkB), .crcOut(crcOutB), .errCnt(errCntB)
    );

    int nCompared   = 0;
    int nMismatched = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reflected X25 CRC over a whole byte queue, preset 0xFFFF, no final xor.
    function automatic logic [15:0] crcReflOf(input byteQ q);
        logic [15:0] r;
        r = 16'hFFFF;
        foreach (q[i]) begin
            r = r ^ {8'h00, q[i]};
            for (int b = 0; b < 8; b++) begin
                r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bitRev16(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = v[15-i];
        return r;
    endfunction

    function automatic byteQ withFcs(input byteQ p);
        byteQ        f;
        logic [15:0] fcs;
        f   = p;
        fcs = ~crcReflOf(p);
        f.push_back(fcs[7:0]);
        f.push_back(fcs[15:8]);
        return f;
    endfunction

    // ---------------- reference model ----------------
    byteQ        frameQ;
    bit          inFrame = 1'b0;
    logic        expValid, expSof, expEof, expDone, expOkA, expOkB;
    logic [7:0]  expData;
    logic [15:0] expCrc;
    int          expErrA, expErrB;

    task automatic modelStep();
        int   n;
        logic good;
        expValid = 1'b0; expSof = 1'b0; expEof = 1'b0;
        expDone  = 1'b0; expOkA = 1'b0; expOkB = 1'b0;
        if (!rstN) begin
            frameQ.delete();
            inFrame = 1'b0;
            expData = 8'h00;
            expCrc  = 16'hFFFF;
            expErrA = 0;
            expErrB = 0;
            return;
        end
        if (inValid && (inSof || inFrame)) begin
            if (inSof) begin
                expDone = inFrame;          // abort of the frame in progress
                frameQ.delete();
                inFrame = 1'b1;
            end
            frameQ.push_back(inData);
            n      = frameQ.size();
            expCrc = bitRev16(crcReflOf(frameQ));
`ifdef CRC_CHK_STRIP_EN
            if (n >= 3) begin
                expValid = 1'b1;
                expData  = frameQ[n-3];
                expSof   = (n == 3);
                expEof   = inEof;
            end
`else
            expValid = 1'b1;
            expData  = inData;
            expSof   = inSof;
            expEof   = inEof;
`endif
            if (inEof) begin
                good    = (crcReflOf(frameQ) == 16'hF0B8) && (n >= 3);
                expDone = 1'b1;
                expOkA  = good && (n <= MAX_A + 2);
                expOkB  = good && (n <= MAX_B + 2);
                inFrame = 1'b0;
            end
        end
        if (expDone && !expOkA && expErrA < 65535) expErrA++;
        if (expDone && !expOkB && expErrB < 3)     expErrB++;
    endtask

    task automatic cmpDut(input string tag, input logic v, input logic [7:0] d,
                          input logic s, input logic e, input logic done, input logic ok,
                          input logic [15:0] crc, input logic [31:0] err,
                          input logic eOk, input int eErr);
        check({tag, ".outValid"},  32'(v),    32'(expValid));
        check({tag, ".frameDone"}, 32'(done), 32'(expDone));
        check({tag, ".crcOut"},    32'(crc),  32'(expCrc));
        check({tag, ".errCnt"},    err,       32'(eErr));
        if (expValid) begin
            check({tag, ".outData"}, 32'(d), 32'(expData));
            check({tag, ".outSof"},  32'(s), 32'(expSof));
            check({tag, ".outEof"},  32'(e), 32'(expEof));
        end
        if (expDone) check({tag, ".frameOk"}, 32'(ok), 32'(eOk));
    endtask

    // Compare process: model advances on each rising edge, outputs sampled 1ns later.
    initial begin
        forever begin
            @(posedge clk);
            modelStep();
            #1;
            cmpDut("A", outValidA, outDataA, outSofA, outEofA, frameDoneA, frameOkA,
                   crcOutA, 32'(errCntA), expOkA, expErrA);
            cmpDut("B", outValidB, outDataB, outSofB, outEofB, frameDoneB, frameOkB,
                   crcOutB, 32'(errCntB), expOkB, expErrB);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            inValid = 1'b0;
            inData  = 8'($urandom);
            inSof   = 1'($urandom);
            inEof   = 1'($urandom);
            @(negedge clk);
        end
        inSof = 1'b0;
        inEof = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] d, input logic s, input logic e, input int maxGap);
        if (maxGap > 0) idleCycles(int'($urandom_range(0, maxGap)));
        inValid = 1'b1;
        inData  = d;
        inSof   = s;
        inEof   = e;
        @(negedge clk);
        inValid = 1'b0;
        inSof   = 1'b0;
        inEof   = 1'b0;
    endtask

    task automatic sendFrame(input byteQ q, input int maxGap, input bit withEof);
        for (int i = 0; i < q.size(); i++) begin
            sendByte(q[i], i == 0, withEof && (i == q.size() - 1), maxGap);
        end
    endtask

    function automatic byteQ randPayload(input int n);
        byteQ p;
        for (int i = 0; i < n; i++) p.push_back(8'($urandom));
        return p;
    endfunction

    task automatic checkResetState();
        check("rst.A.outValid",  32'(outValidA),  32'h0);
        check("rst.A.outData",   32'(outDataA),   32'h0);
        check("rst.A.outSof",    32'(outSofA),    32'h0);
        check("rst.A.outEof",    32'(outEofA),    32'h0);
        check("rst.A.frameDone", 32'(frameDoneA), 32'h0);
        check("rst.A.frameOk",   32'(frameOkA),   32'h0);
        check("rst.A.crcOut",    32'(crcOutA),    32'hFFFF);
        check("rst.A.errCnt",    32'(errCntA),    32'h0);
        check("rst.B.outValid",  32'(outValidB),  32'h0);
        check("rst.B.crcOut",    32'(crcOutB),    32'hFFFF);
        check("rst.B.errCnt",    32'(errCntB),    32'h0);
    endtask

    initial begin
        byteQ        t1, f, p;
        logic [15:0] fcs;
        int          kind;
        int          gap;

        t1 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};

        // Pin the model: standard X25 check value of "123456789".
        fcs = ~crcReflOf(t1);
        check("model.x25_check", 32'(fcs), 32'h906E);

        idleCycles(3);
        checkResetState();
        rstN = 1'b1;
        idleCycles(2);

        // 1: good frame
        sendFrame(withFcs(t1), 0, 1'b1);
        check("t1.A.frameDone", 32'(frameDoneA), 32'h1);
        check("t1.A.frameOk",   32'(frameOkA),   32'h1);
        check("t1.A.crcOut",    32'(crcOutA),    32'h1D0F);
        check("t1.A.errCnt",    32'(errCntA),    32'h0);
        check("t1.B.frameOk",   32'(frameOkB),   32'h0);
        idleCycles(2);

        // 2: corrupted FCS
        f = t1;
        f.push_back(8'h6F);
        f.push_back(8'h90);
        sendFrame(f, 0, 1'b1);
        check("t2.A.frameOk", 32'(frameOkA), 32'h0);
        check("t2.A.errCnt",  32'(errCntA),  32'h1);
        idleCycles(1);

        // 3: two-byte frame is always bad
        sendFrame('{8'h6E, 8'h90}, 0, 1'b1);
        check("t3.A.frameOk", 32'(frameOkA), 32'h0);
        check("t3.A.errCnt",  32'(errCntA),  32'h2);
        idleCycles(1);

        // 4: abort after 4 bytes, then a good frame
        sendFrame('{8'h31, 8'h32, 8'h33, 8'h34}, 0, 1'b0);
        sendFrame(withFcs(t1), 0, 1'b1);
        check("t4.A.frameOk", 32'(frameOkA), 32'h1);
        check("t4.A.errCnt",  32'(errCntA),  32'h3);
        check("t4.B.errCnt",  32'(errCntB),  32'h3);
        idleCycles(1);

        // 5: gaps, then reset mid-frame, then good frame again
        sendFrame(withFcs(t1), 3, 1'b1);
        check("t5.A.frameOk", 32'(frameOkA), 32'h1);
        sendFrame('{8'h31, 8'h32, 8'h33, 8'h34, 8'h35}, 3, 1'b0);
        rstN = 1'b0;
        idleCycles(2);
        checkResetState();
        rstN = 1'b1;
        idleCycles(1);
        sendFrame(withFcs(t1), 0, 1'b1);
        check("t5.A.frameOk_after_rst", 32'(frameOkA), 32'h1);
        check("t5.A.errCnt_after_rst",  32'(errCntA),  32'h0);
        idleCycles(1);

        // 6: length limits on dutB (MAX_LEN=4) and counter saturation
        sendFrame(withFcs(randPayload(5)), 0, 1'b1);
        check("t6.A.len7_ok", 32'(frameOkA), 32'h1);
        check("t6.B.len7_ok", 32'(frameOkB), 32'h0);
        sendFrame(withFcs(randPayload(4)), 0, 1'b1);
        check("t6.B.len6_ok", 32'(frameOkB), 32'h1);
        sendFrame(withFcs(randPayload(0)), 0, 1'b1);
        check("t6.A.len2_ok", 32'(frameOkA), 32'h0);
        sendFrame(withFcs(randPayload(1)), 0, 1'b1);
        check("t6.A.len3_ok", 32'(frameOkA), 32'h1);
        for (int i = 0; i < 3; i++) sendFrame('{8'h6E, 8'h90}, 1, 1'b1);
        check("t6.B.errCnt_sat", 32'(errCntB), 32'h3);
        check("t6.A.errCnt",     32'(errCntA), 32'h4);
        idleCycles(2);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            kind = int'($urandom_range(0, 9));
            gap  = int'($urandom_range(0, 3));
            p    = randPayload(int'($urandom_range(0, 8)));
            if (kind <= 4) begin
                sendFrame(withFcs(p), gap, 1'b1);
            end else if (kind <= 6) begin
                f = withFcs(p);
                f[f.size()-1] = f[f.size()-1] ^ 8'(1 << $urandom_range(0, 7));
                sendFrame(f, gap, 1'b1);
            end else if (kind == 7) begin
                sendFrame(withFcs(p), gap, 1'b0);
                sendFrame(withFcs(randPayload(3)), gap, 1'b1);
            end else if (kind == 8) begin
                for (int j = 0; j < 3; j++) sendByte(8'($urandom), 1'b0, 1'($urandom), gap);
            end else begin
                sendByte(8'($urandom), 1'b1, 1'b1, gap);
            end
            if (it % 97 == 50) begin
                sendFrame(withFcs(p), gap, 1'b0);
                rstN = 1'b0;
                idleCycles(2);
                rstN = 1'b1;
            end
            idleCycles(int'($urandom_range(0, 2)));
        end

        idleCycles(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
